// File: rtl/box_plotter.sv
// Box plotter: streams one pixel per clock of a filled or outline-only box
// to the VGA adapter write port, with a start/busy/done handshake.
module box_plotter #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3,
   parameter int SIZE_W   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [X_W-1:0]      x_in,
   input  logic [Y_W-1:0]      y_in,
   input  logic [SIZE_W-1:0]   w_m1,
   input  logic [SIZE_W-1:0]   h_m1,
   input  logic [COLOUR_W-1:0] colour_in,
   input  logic                outline,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Box parameters captured at start; the request inputs are free afterwards.
   logic [X_W-1:0]      x0;
   logic [Y_W-1:0]      y0;
   logic [SIZE_W-1:0]   w_l, h_l;
   logic [COLOUR_W-1:0] col_l;
   logic                outl_l;

   // cx/cy index the pixel currently presented on the outputs, so pixel 0
   // is loaded straight from the inputs on the accepting edge.
   logic [SIZE_W-1:0]   cx, cy, cx_nxt, cy_nxt;
   logic [X_W-1:0]      x_nxt;
   logic [Y_W-1:0]      y_nxt;
   logic [COLOUR_W-1:0] colour_nxt;
   logic                plot_nxt;
   logic                accept, last;

   // A request is taken whenever no box is in flight (IDLE or DONE).
   assign accept = start && (state != S_DRAW);
   assign last   = (cx == w_l) && (cy == h_l);
   assign busy   = (state == S_DRAW);
   assign done   = (state == S_DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_DRAW;
         S_DRAW:  if (last)  state_nxt = S_DONE;
         S_DONE:  state_nxt = start ? S_DRAW : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next pixel: load pixel 0 on accept, otherwise raster-advance while drawing.
   always_comb begin
      cx_nxt     = cx;
      cy_nxt     = cy;
      x_nxt      = x_out;
      y_nxt      = y_out;
      colour_nxt = colour_out;
      plot_nxt   = 1'b0;
      if (accept) begin
         cx_nxt     = '0;
         cy_nxt     = '0;
         x_nxt      = x_in;
         y_nxt      = y_in;
         colour_nxt = colour_in;
         plot_nxt   = 1'b1;
      end else if ((state == S_DRAW) && !last) begin
         if (cx == w_l) begin
            cx_nxt = '0;
            cy_nxt = cy + SIZE_W'(1);
         end else begin
            cx_nxt = cx + SIZE_W'(1);
         end
         x_nxt      = x0 + X_W'(cx_nxt);
         y_nxt      = y0 + Y_W'(cy_nxt);
         colour_nxt = col_l;
         plot_nxt   = !outl_l || (cx_nxt == '0) || (cx_nxt == w_l) ||
                      (cy_nxt == '0) || (cy_nxt == h_l);
      end
   end

   // Pixel output and counter registers; held between boxes with plot low.
   always_ff @(posedge clk) begin
      if (reset) begin
         cx         <= '0;
         cy         <= '0;
         x_out      <= '0;
         y_out      <= '0;
         colour_out <= '0;
         plot       <= 1'b0;
      end else begin
         cx         <= cx_nxt;
         cy         <= cy_nxt;
         x_out      <= x_nxt;
         y_out      <= y_nxt;
         colour_out <= colour_nxt;
         plot       <= plot_nxt;
      end
   end

   // Capture the request parameters when a box is accepted.
   always_ff @(posedge clk) begin
      if (accept) begin
         x0     <= x_in;
         y0     <= y_in;
         w_l    <= w_m1;
         h_l    <= h_m1;
         col_l  <= colour_in;
         outl_l <= outline;
      end
   end

endmodule
